// File: rtl/line_raster_pkg.sv
// Shared raster types and helpers for the line, fill and triangle rasterisers.
// Latency: none; this file holds types and pure functions only.
// Backpressure: none; nothing here is clocked.
package line_raster_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SETUP,
        ST_STEP,
        ST_FLUSH,
        ST_DONE
    } raster_state_t;

    // Helpers work at a fixed maximum coordinate width.
    // Callers sign-extend into coord_max_t and slice the result back down,
    // so any COORD_WIDTH below COORD_MAX_W is served by the same function.
    localparam int COORD_MAX_W = 32;
    typedef logic signed [COORD_MAX_W-1:0] coord_max_t;

    // |a-b|, computed one bit wider than the inputs so it never overflows.
    function automatic logic [COORD_MAX_W:0] abs_diff(input coord_max_t a, input coord_max_t b);
        logic signed [COORD_MAX_W:0] d;
        d = {a[COORD_MAX_W-1], a} - {b[COORD_MAX_W-1], b};
        return d[COORD_MAX_W] ? -d : d;
    endfunction

    // Inside the viewport 0..w-1 by 0..h-1, using a signed compare.
    function automatic logic in_viewport(input coord_max_t x, input coord_max_t y,
                                         input int w, input int h);
        return !x[COORD_MAX_W-1] && (x < w) && !y[COORD_MAX_W-1] && (y < h);
    endfunction

endpackage

// File: rtl/line_raster_stream.sv
// Bresenham line rasteriser covering all octants, with viewport clipping and a one-entry pixel output register.
// Latency: first pixel is valid 3 cycles after command accept; then 1 point/cycle; clipped points cost 1 cycle each.
// Backpressure: a stalled visible point waits for pix_ready; pix_* hold stable while pix_valid && !pix_ready.
// Ports: cmd_* is a valid/ready command carrying endpoints and attr. pix_* is a valid/ready pixel stream.
//        busy, done and pix_count are status outputs. clk_in is the clock; rst_n_in is an async active-low reset.
module line_raster_stream
    import line_raster_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int ATTR_WIDTH  = 8,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 180,
    parameter bit CLIP_EN     = 1'b1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic signed [COORD_WIDTH-1:0] cmd_x0,
    input  logic signed [COORD_WIDTH-1:0] cmd_y0,
    input  logic signed [COORD_WIDTH-1:0] cmd_x1,
    input  logic signed [COORD_WIDTH-1:0] cmd_y1,
    input  logic [ATTR_WIDTH-1:0]         cmd_attr,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic signed [COORD_WIDTH-1:0] pix_x,
    output logic signed [COORD_WIDTH-1:0] pix_y,
    output logic [ATTR_WIDTH-1:0]         pix_attr,
    output logic                          busy,
    output logic                          done,
    output logic [COORD_WIDTH:0]          pix_count
);

    localparam int ERR_W = COORD_WIDTH + 2;
    localparam logic signed [COORD_WIDTH-1:0] C_ONE    = COORD_WIDTH'(1);
    localparam logic [COORD_WIDTH:0]          CNT_ONE  = (COORD_WIDTH+1)'(1);
    localparam logic signed [ERR_W-1:0]       ERR_ZERO = '0;

    raster_state_t                 state;
    logic signed [COORD_WIDTH-1:0] x0_q, y0_q, x1_q, y1_q, cur_x, cur_y;
    logic [ATTR_WIDTH-1:0]         attr_q;
    logic signed [COORD_WIDTH:0]   dx, dy;
    logic                          sx_neg, sy_neg;
    logic signed [ERR_W-1:0]       err, e2, dx_w, dy_w, err_nxt;
    logic [COORD_MAX_W:0]          adx_full, ady_full;
    logic [COORD_MAX_W-COORD_WIDTH-1:0] unused_adiff_hi;
    logic                          visible, adv, load, at_end, step_x, step_y;

    assign adx_full = abs_diff(coord_max_t'(x1_q), coord_max_t'(x0_q));
    assign ady_full = abs_diff(coord_max_t'(y1_q), coord_max_t'(y0_q));
    // The upper bits are always zero for legal COORD_WIDTH inputs.
    assign unused_adiff_hi = adx_full[COORD_MAX_W:COORD_WIDTH+1] ^ ady_full[COORD_MAX_W:COORD_WIDTH+1];

    assign visible = !CLIP_EN ||
                     in_viewport(coord_max_t'(cur_x), coord_max_t'(cur_y), SCREEN_W, SCREEN_H);
    // A clipped point never waits on the output register; it is just skipped.
    assign adv     = (state == ST_STEP) && (!visible || !pix_valid || pix_ready);
    assign load    = adv && visible;
    assign at_end  = (cur_x == x1_q) && (cur_y == y1_q);

    assign dx_w    = ERR_W'(dx);
    assign dy_w    = ERR_W'(dy);
    assign e2      = err <<< 1;
    assign step_x  = (e2 >= dy_w);
    assign step_y  = (e2 <= dx_w);
    // Diagonal steps apply both corrections in the same cycle.
    assign err_nxt = err + (step_x ? dy_w : ERR_ZERO) + (step_y ? dx_w : ERR_ZERO);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_attr  <= '0;
            pix_count <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            attr_q    <= '0;
            dx        <= '0;
            dy        <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            err       <= '0;
        end else begin
            done <= 1'b0;

            // Output register: a new load wins over a drain in the same cycle.
            if (load) begin
                pix_valid <= 1'b1;
                pix_x     <= cur_x;
                pix_y     <= cur_y;
                pix_attr  <= attr_q;
                pix_count <= pix_count + CNT_ONE;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        x0_q      <= cmd_x0;
                        y0_q      <= cmd_y0;
                        x1_q      <= cmd_x1;
                        y1_q      <= cmd_y1;
                        attr_q    <= cmd_attr;
                        pix_count <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    dx     <= adx_full[COORD_WIDTH:0];
                    dy     <= -$signed(ady_full[COORD_WIDTH:0]);
                    sx_neg <= !(x0_q < x1_q);
                    sy_neg <= !(y0_q < y1_q);
                    state  <= ST_SETUP;
                end
                ST_SETUP: begin
                    err   <= dx_w + dy_w;
                    cur_x <= x0_q;
                    cur_y <= y0_q;
                    state <= ST_STEP;
                end
                ST_STEP: begin
                    if (adv) begin
                        if (at_end) begin
                            state <= ST_FLUSH;
                        end else begin
                            err <= err_nxt;
                            if (step_x) cur_x <= sx_neg ? cur_x - C_ONE : cur_x + C_ONE;
                            if (step_y) cur_y <= sy_neg ? cur_y - C_ONE : cur_y + C_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!pix_valid || pix_ready) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster_stream.sv
// Directed bench for line_raster_stream: hand-computed pixel lists, timing, clipping, backpressure and reset abort.
// Latency: cycle numbers count posedges after the command-accept edge (edge 0).
// Backpressure: pix_ready is driven here; it is either held at 1 or randomised per cycle.
module tb_line_raster_stream;

    localparam int CW = 16;
    localparam int AW = 8;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic                 cmd_valid;
    logic                 cmd_ready, u1_cmd_ready;
    logic signed [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [AW-1:0]        cmd_attr;
    logic                 pix_valid, u1_pix_valid;
    logic                 pix_ready;
    logic                 u1_pix_ready = 1'b1;
    logic signed [CW-1:0] pix_x, pix_y, u1_pix_x, u1_pix_y;
    logic [AW-1:0]        pix_attr, u1_pix_attr;
    logic                 busy, done, u1_busy, u1_done;
    logic [CW:0]          pix_count, u1_pix_count;

    always #5 clk_in = ~clk_in;

    line_raster_stream #(.COORD_WIDTH(CW), .ATTR_WIDTH(AW), .SCREEN_W(320), .SCREEN_H(180), .CLIP_EN(1'b1)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_attr(cmd_attr),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_attr(pix_attr),
        .busy(busy), .done(done), .pix_count(pix_count)
    );

    line_raster_stream #(.COORD_WIDTH(CW), .ATTR_WIDTH(AW), .SCREEN_W(320), .SCREEN_H(180), .CLIP_EN(1'b0)) u1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .cmd_valid(cmd_valid), .cmd_ready(u1_cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_attr(cmd_attr),
        .pix_valid(u1_pix_valid), .pix_ready(u1_pix_ready),
        .pix_x(u1_pix_x), .pix_y(u1_pix_y), .pix_attr(u1_pix_attr),
        .busy(u1_busy), .done(u1_done), .pix_count(u1_pix_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    int px_q[$], py_q[$], pa_q[$];
    int exp_x[$], exp_y[$];
    int first_vld, done_edge, done_cnt, cnt_at_done, stall_err, u1_hs, u1_cnt;
    int done_after, rdy_after, attr_err, seen, done_seen;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pix(input string tag);
        chk({tag, "_count"}, px_q.size(), exp_x.size());
        for (int i = 0; i < exp_x.size(); i++) begin
            chk($sformatf("%s_x%0d", tag, i), (i < px_q.size()) ? px_q[i] : -9999, exp_x[i]);
            chk($sformatf("%s_y%0d", tag, i), (i < py_q.size()) ? py_q[i] : -9999, exp_y[i]);
        end
    endtask

    // Entered and left at a negedge. Records every handshaked pixel, the
    // first-valid and done cycles, and output stability across stalls.
    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int attr, input bit bp);
        bit stalled = 1'b0;
        int hx = 0, hy = 0, ha = 0;
        px_q.delete(); py_q.delete(); pa_q.delete();
        first_vld = -1; done_edge = -1; done_cnt = 0; cnt_at_done = -1;
        stall_err = 0; u1_hs = 0; u1_cnt = -1;
        cmd_x0 = CW'(x0); cmd_y0 = CW'(y0); cmd_x1 = CW'(x1); cmd_y1 = CW'(y1);
        cmd_attr = AW'(attr);
        cmd_valid = 1'b1;
        chk("cmd_ready_at_offer", int'(cmd_ready), 1);
        @(posedge clk_in);
        @(negedge clk_in);
        cmd_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (stalled && (!pix_valid || int'(pix_x) != hx || int'(pix_y) != hy || int'(pix_attr) != ha))
                stall_err++;
            if (pix_valid && first_vld < 0) first_vld = n;
            if (u1_pix_valid) u1_hs++;
            if (done) begin
                done_cnt++;
                done_edge   = n;
                cnt_at_done = int'(pix_count);
                u1_cnt      = int'(u1_pix_count);
                break;
            end
            pix_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (pix_valid && pix_ready) begin
                px_q.push_back(int'(pix_x));
                py_q.push_back(int'(pix_y));
                pa_q.push_back(int'(pix_attr));
            end
            stalled = pix_valid && !pix_ready;
            hx = int'(pix_x); hy = int'(pix_y); ha = int'(pix_attr);
            @(posedge clk_in);
            @(negedge clk_in);
        end
        pix_ready = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        done_after = int'(done);
        rdy_after  = int'(cmd_ready);
    endtask

    initial begin
        rst_n_in = 1'b0; cmd_valid = 1'b0; pix_ready = 1'b1;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_attr = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_pix_attr", int'(pix_attr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pix_count", int'(pix_count), 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Horizontal line, timing exact.
        run_line(0, 0, 3, 0, 'h11, 1'b0);
        exp_x = '{0, 1, 2, 3}; exp_y = '{0, 0, 0, 0};
        check_pix("hz");
        chk("hz_first_valid_cycle", first_vld, 3);
        chk("hz_done_cycle", done_edge, 7);
        chk("hz_done_cnt", done_cnt, 1);
        chk("hz_pix_count", cnt_at_done, 4);
        chk("hz_attr", (pa_q.size() > 0) ? pa_q[0] : -1, 'h11);
        chk("hz_done_one_cycle", done_after, 0);
        chk("hz_cmd_ready_after_done", rdy_after, 1);

        // Steep line drawn from the far endpoint, both steps negative.
        run_line(2, 5, 0, 0, 'h22, 1'b0);
        exp_x = '{2, 2, 1, 1, 0, 0}; exp_y = '{5, 4, 3, 2, 1, 0};
        check_pix("steep");
        chk("steep_done_cnt", done_cnt, 1);
        chk("steep_pix_count", cnt_at_done, 6);

        // Clipping: two off-screen points cost cycles but emit nothing.
        run_line(-2, 1, 2, 1, 'h33, 1'b0);
        exp_x = '{0, 1, 2}; exp_y = '{1, 1, 1};
        check_pix("clip");
        chk("clip_pix_count", cnt_at_done, 3);
        chk("clip_done_cnt", done_cnt, 1);
        chk("clip_done_cycle", done_edge, 8);
        chk("noclip_pix_count", u1_cnt, 5);
        chk("noclip_handshakes", u1_hs, 5);

        // Degenerate point, then back-to-back commands.
        run_line(7, 7, 7, 7, 'hA5, 1'b0);
        exp_x = '{7}; exp_y = '{7};
        check_pix("degen");
        chk("degen_attr", (pa_q.size() > 0) ? pa_q[0] : -1, 'hA5);
        chk("degen_pix_count", cnt_at_done, 1);
        chk("degen_done_cycle", done_edge, 4);

        run_line(0, 0, 7, 3, 'h44, 1'b0);
        exp_x = '{0, 1, 2, 3, 4, 5, 6, 7}; exp_y = '{0, 0, 1, 1, 2, 2, 3, 3};
        check_pix("shallow");
        chk("shallow_pix_count", cnt_at_done, 8);

        // Same line under random backpressure.
        run_line(0, 0, 7, 3, 'h55, 1'b1);
        check_pix("bp");
        chk("bp_stall_stable", stall_err, 0);
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_pix_count", cnt_at_done, 8);
        attr_err = 0;
        foreach (pa_q[i]) if (pa_q[i] != 'h55) attr_err++;
        chk("bp_attr", attr_err, 0);

        // Reset while the third pixel is on the output.
        cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 10; cmd_y1 = 0; cmd_attr = 'h77;
        cmd_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        cmd_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 50 && seen == 0; n++) begin
            if (pix_valid && int'(pix_x) == 2) seen = 1;
            else @(negedge clk_in);
        end
        chk("rst_mid_third_pixel_seen", seen, 1);
        rst_n_in = 1'b0;
        #1;
        chk("rst_mid_pix_valid", int'(pix_valid), 0);
        chk("rst_mid_pix_x", int'(pix_x), 0);
        chk("rst_mid_pix_attr", int'(pix_attr), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_cmd_ready", int'(cmd_ready), 1);
        chk("rst_mid_pix_count", int'(pix_count), 0);
        done_seen = 0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk_in);
            if (done) done_seen++;
        end
        rst_n_in = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_in);
            if (done) done_seen++;
        end
        chk("rst_mid_no_done", done_seen, 0);

        run_line(1, 2, 3, 2, 'h66, 1'b0);
        exp_x = '{1, 2, 3}; exp_y = '{2, 2, 2};
        check_pix("post_rst");
        chk("post_rst_first_valid_cycle", first_vld, 3);
        chk("post_rst_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
